// File: rtl/give_out_if.sv
// Packet write port and two-key serial line of the give_out transmitter.
// master = packet source / line observer, slave = the transmitter itself.
interface give_out_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          wr_en;
   logic [3:0]    wr_data;
   logic          wr_full;
   logic [LW-1:0] fifo_level;
   logic          start;
   logic          key0;
   logic          key1;
   logic          busy;
   logic [7:0]    sent_count;
   logic [7:0]    overflow_count;

   modport master (
      output wr_en, wr_data,
      input  wr_full, fifo_level, start, key0, key1, busy, sent_count, overflow_count
   );

   modport slave (
      input  wr_en, wr_data,
      output wr_full, fifo_level, start, key0, key1, busy, sent_count, overflow_count
   );
endinterface

// File: rtl/give_out.sv
// Queues 4-bit packets and replays each as a start-low preamble plus four active-low key pulses, MSB first.
// First start-low one cycle after the write; a write while full is dropped unless IDLE pops on the same edge.
module give_out #(
   parameter int DEPTH        = 4,
   parameter int START_CYCLES = 3,
   parameter int GAP_CYCLES   = 1
) (
   input  logic      clk,
   input  logic      reset,
   give_out_if.slave bus
);
   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int CMAX = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_GAP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, full_d;
   logic [3:0]    shreg_q, shreg_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          start_q, start_d;
   logic          key0_q, key0_d;
   logic          key1_q, key1_d;
   logic          busy_q, busy_d;
   logic [7:0]    sent_q, sent_d;
   logic [7:0]    ovf_q, ovf_d;
   logic          pop;
   logic          push;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      shreg_d  = shreg_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      sent_d   = sent_q;
      ovf_d    = ovf_q;

      // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
      pop  = (state_q == S_IDLE) && (level_q != '0);
      push = bus.wr_en && (!full_q || pop);

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
      if (bus.wr_en && !push && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               shreg_d = mem_q[rd_ptr_q];
               cnt_d   = CW'(START_CYCLES);
               idx_d   = 2'd3;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_BIT;
         end
         S_BIT: begin
            cnt_d   = CW'(GAP_CYCLES);
            state_d = S_GAP;
         end
         S_GAP: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               if (idx_q != 2'd0) begin
                  idx_d   = idx_q - 2'd1;
                  state_d = S_BIT;
               end else begin
                  sent_d  = sent_q + 8'd1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Line outputs are registered from the next state so they change with it.
      full_d  = (level_d == LW'(DEPTH));
      start_d = (state_d != S_START);
      key0_d  = !((state_d == S_BIT) && !shreg_d[idx_d]);
      key1_d  = !((state_d == S_BIT) &&  shreg_d[idx_d]);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         shreg_q  <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         start_q  <= 1'b1;
         key0_q   <= 1'b1;
         key1_q   <= 1'b1;
         busy_q   <= 1'b0;
         sent_q   <= '0;
         ovf_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         shreg_q  <= shreg_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         start_q  <= start_d;
         key0_q   <= key0_d;
         key1_q   <= key1_d;
         busy_q   <= busy_d;
         sent_q   <= sent_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   assign bus.wr_full        = full_q;
   assign bus.fifo_level     = level_q;
   assign bus.start          = start_q;
   assign bus.key0           = key0_q;
   assign bus.key1           = key1_q;
   assign bus.busy           = busy_q;
   assign bus.sent_count     = sent_q;
   assign bus.overflow_count = ovf_q;
endmodule

// File: doc/give_out.md
# give_out

Transmitter for the two-key serial packet protocol used by the keypad packet receiver. It accepts 4-bit packets from a local source into a small FIFO and replays each one as a start-low preamble followed by four one-cycle key pulses, MSB first. Each pulse is active-low, on key0 for a 0 and on key1 for a 1. It sits in front of the receiver in loopback and self-test builds, replacing the physical push buttons.

## Interface
- DEPTH, 4: packet FIFO depth (power of two, 2..8).
- START_CYCLES, 3: number of cycles start is held low before the first bit.
- GAP_CYCLES, 1: idle cycles (both keys high) after each bit pulse, ≥1.

- clk  input  1  rising-edge clock for all logic.
- reset  input  1  asynchronous, active-high; clears FIFO, FSM and counters.
- wr_en  input  1  write strobe; accepted on a rising clk edge when the FIFO is not full.
- wr_data  input  4  packet: [3:2] selects buffer 1–4, [1:0] is payload.
- wr_full  output  1  FIFO full; a write is ignored while it is high.
- fifo_level  output  $clog2(DEPTH)+1  packets currently queued.
- start  output  1  protocol start line, active-low; idles high.
- key0  output  1  active-low "bit = 0" pulse; idles high.
- key1  output  1  active-low "bit = 1" pulse; idles high.
- busy  output  1  high whenever the FSM is not in IDLE.
- sent_count  output  8  packets fully transmitted; wraps 255→0.
- overflow_count  output  8  writes rejected while full; saturates at 255.

## Operation
- All outputs are registered. Reset values:
  - start=1, key0=1, key1=1.
  - busy=0, wr_full=0, fifo_level=0.
  - sent_count=0, overflow_count=0.
- FIFO behaviour:
  - Circular buffer with read and write pointers, DEPTH entries.
  - A write while full is dropped, the FIFO is unchanged, and overflow_count increments.
  - A write and a pop on the same edge are both performed, so fifo_level is unchanged. This applies even when full: the pop frees a slot, so the write is accepted.
- FSM states: IDLE, START, BIT, GAP.
  - IDLE: if the FIFO is not empty, pop the head into a 4-bit shift register, load the start counter with START_CYCLES, set bit_idx=3 and go to START. Otherwise stay in IDLE.
  - START: start=0, keys high. Decrement the counter. When it reaches 1, go to BIT.
  - BIT: start=1. Drive key0=0 if shreg[bit_idx]==0, otherwise key1=0. Exactly one key is low. Load the gap counter with GAP_CYCLES and go to GAP.
  - GAP: both keys high, start=1. When the gap counter expires:
    - if bit_idx≠0, decrement bit_idx and go to BIT;
    - otherwise increment sent_count and go to IDLE.
- key0 and key1 are never low simultaneously. Neither key is ever low while start=0.
- Bit order is wr_data[3], [2], [1], [0], so the receiver rebuilds the packet in the original order.
- Reset asserted mid-packet: outputs return to idle levels immediately, without waiting for clk. The packet in flight is lost and not counted, and queued packets are discarded.

## Timing
Edges below are numbered from the write edge E0 (wr_en sampled, FIFO empty, FSM idle), with START_CYCLES=3 and GAP_CYCLES=1.
- After E0: fifo_level=1.
- After E1: IDLE pops the packet. busy=1, fifo_level=0, start=0.
- After E2 and E3: start stays 0.
- After E4: start=1 and the bit-3 key pulse is driven for one cycle.
- After E5: GAP.
- Bit 2 is driven after E6, bit 1 after E8, and bit 0 after E10.
- After E11: the last GAP cycle.
- After E12: sent_count increments and busy=0.
- Packet occupancy is START_CYCLES + 4·(1+GAP_CYCLES) = 11 cycles.
- Back-to-back packets: the next start-low begins 1 cycle after returning to IDLE, giving a period of 12 cycles.
- wr_full is high exactly when fifo_level==DEPTH, and it updates on the same edge as the level.

## Test plan
- Reset, then write 4'b1011 at E0.
  - start is low for 3 cycles (after E1–E3).
  - Pulses follow: key1, key0, key1, key1 after E4, E6, E8, E10.
  - sent_count=1 after E12.
- Write 5 packets back-to-back (DEPTH=4) while idle.
  - The first pops at E1, so all 5 are accepted and overflow_count=0.
  - A 6th and 7th write during transmission give wr_full=1 and overflow_count=2.
  - After draining, sent_count=5.
- Write 4'b0000 and 4'b1111 consecutively.
  - Only key0 pulses occur for the first packet, only key1 pulses for the second.
  - The second start-low begins 12 cycles after the first.
- Assert reset for one cycle at the bit-1 pulse of a packet, with 2 packets queued.
  - start, key0 and key1 go high asynchronously.
  - fifo_level=0 and sent_count=0.
  - No further pulses occur.
- Run a 300-packet stream.
  - sent_count wraps 255→0 and reaches 44.
  - A concurrent assertion confirms the keys are never both low and never low while start=0.
- With the FIFO full, assert wr_en on the same edge IDLE pops.
  - The write is accepted, fifo_level stays at 4, and overflow_count is unchanged.
